usb_link_ctrl: RTL and testbench

//  Byte-stream front end for usb_bridge. Buffers outbound user bytes in a TX FIFO and turns

---
 rtl/usb_link_pkg.sv | 18 +
 rtl/usb_link_fifo.sv | 44 ++++
 rtl/usb_link_ctrl.sv | 129 ++++++++++++
 tb/tb_usb_link_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_link_pkg.sv
// usb_link_pkg: shared FSM/grant encodings and pending-read arithmetic for usb_link_ctrl.
package usb_link_pkg;

   typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;
   typedef enum logic {GRANT_WR, GRANT_RD} grant_e;

   localparam int RD_PEND_W = 16;

   // Add and completion-decrement net out before saturating at all-ones.
   function automatic logic [RD_PEND_W-1:0] pend_next(input logic [RD_PEND_W-1:0] p,
                                                      input logic [7:0]           add,
                                                      input logic                 dec);
      logic [RD_PEND_W:0] s;
      s = {1'b0, p} + (RD_PEND_W+1)'(add) - (RD_PEND_W+1)'(dec);
      return s[RD_PEND_W] ? '1 : s[RD_PEND_W-1:0];
   endfunction

endpackage

// File: rtl/usb_link_fifo.sv
// usb_link_fifo: synchronous show-ahead FIFO; push and pop may coincide at any level,
// including full (pop frees the slot being written) and empty (pop is ignored).
module usb_link_fifo #(
   parameter int DATA_W = 8,
   parameter int AW     = 4,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] data_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [AW:0]       level_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW:0]       wr_q, rd_q;
   logic              wr_en, rd_en;

   assign level_o = wr_q - rd_q;
   assign full_o  = level_o == (AW+1)'(DEPTH);
   assign empty_o = level_o == '0;
   assign rd_en   = pop_i && !empty_o;
   assign wr_en   = push_i && (!full_o || rd_en);
   assign data_o  = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_q + (AW+1)'(wr_en);
         rd_q <= rd_q + (AW+1)'(rd_en);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/usb_link_ctrl.sv
// usb_link_ctrl: byte-stream front end serialising TX-FIFO writes and counted reads onto usb_bridge.
// Define USB_LINK_STATS_EN to add completed-transaction counters tx_count_o/rx_count_o.
module usb_link_ctrl
   import usb_link_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int FIFO_AW    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       tx_data_i,
   input  logic             tx_valid_i,
   output logic             tx_ready_o,
   output logic [7:0]       rx_data_o,
   output logic             rx_valid_o,
   input  logic             rx_ready_i,
   input  logic             rd_start_i,
   input  logic [7:0]       rd_len_i,
   output logic             busy_o,
   output logic [FIFO_AW:0] tx_level_o,
   output logic [FIFO_AW:0] rx_level_o,
   output logic             br_write_sig_o,
   output logic             br_read_sig_o,
   output logic [7:0]       br_write_data_o,
   input  logic [7:0]       br_read_data_i,
   input  logic             br_finished_i
`ifdef USB_LINK_STATS_EN
   ,
   output logic [15:0]      tx_count_o,
   output logic [15:0]      rx_count_o
`endif
);

   state_e                 state_q, state_d;
   grant_e                 last_q, last_d;
   logic [RD_PEND_W-1:0]   pend_q, pend_d;
   logic [7:0]             tx_head;
   logic                   tx_full, tx_empty, rx_full, rx_empty;
   logic                   tx_req, rd_req, wr_done, rd_done;

   usb_link_fifo #(.DATA_W(8), .AW(FIFO_AW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (tx_valid_i && tx_ready_o),
      .data_i  (tx_data_i),
      .pop_i   (wr_done),
      .data_o  (tx_head),
      .full_o  (tx_full),
      .empty_o (tx_empty),
      .level_o (tx_level_o)
   );

   usb_link_fifo #(.DATA_W(8), .AW(FIFO_AW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (rd_done),
      .data_i  (br_read_data_i),
      .pop_i   (rx_valid_o && rx_ready_i),
      .data_o  (rx_data_o),
      .full_o  (rx_full),
      .empty_o (rx_empty),
      .level_o (rx_level_o)
   );

   assign wr_done = state_q == WRITE && br_finished_i;
   assign rd_done = state_q == READ && br_finished_i;
   assign tx_req  = !tx_empty;
   // Only one read is ever in flight, so space at grant time is enough.
   assign rd_req  = pend_q != '0 && !rx_full;
   assign pend_d  = pend_next(pend_q, rd_start_i ? rd_len_i : 8'd0, rd_done);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            if (tx_req && (!rd_req || last_q == GRANT_RD)) state_d = WRITE;
            else if (rd_req) state_d = READ;
         end
         WRITE: if (br_finished_i) begin
            state_d = IDLE;
            last_d  = GRANT_WR;
         end
         READ: if (br_finished_i) begin
            state_d = IDLE;
            last_d  = GRANT_RD;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= GRANT_RD;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         pend_q  <= pend_d;
      end
   end

   // Head is stable through WRITE: the FIFO is non-empty and only pops on completion.
   assign br_write_sig_o  = state_q == WRITE;
   assign br_read_sig_o   = state_q == READ;
   assign br_write_data_o = br_write_sig_o ? tx_head : 8'd0;
   assign tx_ready_o      = !tx_full;
   assign rx_valid_o      = !rx_empty;
   assign busy_o          = state_q != IDLE || !tx_empty || pend_q != '0;

`ifdef USB_LINK_STATS_EN
   logic [15:0] tx_cnt_q, rx_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_cnt_q <= '0;
         rx_cnt_q <= '0;
      end else begin
         tx_cnt_q <= tx_cnt_q + 16'(wr_done);
         rx_cnt_q <= rx_cnt_q + 16'(rd_done);
      end
   end

   assign tx_count_o = tx_cnt_q;
   assign rx_count_o = rx_cnt_q;
`endif

endmodule

// File: tb/tb_usb_link_ctrl.sv
// tb_usb_link_ctrl: randomized bench with a cycle-exact usb_bridge model and a
// queue-based scoreboard monitor checking every cycle against FIFO/pending-count rules.
module tb_usb_link_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b0;
   logic       rd_start = 1'b0;
   logic [7:0] rd_len = '0;
   logic       busy;
   logic [4:0] tx_level, rx_level;
   logic       br_write_sig, br_read_sig;
   logic [7:0] br_write_data;
   logic [7:0] br_read_data = '0;
   logic       br_finished = 1'b0;
`ifdef USB_LINK_STATS_EN
   logic [15:0] tx_count, rx_count;
`endif

   usb_link_ctrl #(.FIFO_DEPTH(16), .FIFO_AW(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .tx_data_i       (tx_data),
      .tx_valid_i      (tx_valid),
      .tx_ready_o      (tx_ready),
      .rx_data_o       (rx_data),
      .rx_valid_o      (rx_valid),
      .rx_ready_i      (rx_ready),
      .rd_start_i      (rd_start),
      .rd_len_i        (rd_len),
      .busy_o          (busy),
      .tx_level_o      (tx_level),
      .rx_level_o      (rx_level),
      .br_write_sig_o  (br_write_sig),
      .br_read_sig_o   (br_read_sig),
      .br_write_data_o (br_write_data),
      .br_read_data_i  (br_read_data),
      .br_finished_i   (br_finished)
`ifdef USB_LINK_STATS_EN
      ,
      .tx_count_o      (tx_count),
      .rx_count_o      (rx_count)
`endif
   );

   always #5 clk = ~clk;

   // Bridge model: IDLE samples a sig (read wins), SETUP, ACCESS, then FINISH raises finished.
   int         bst = 0;
   logic       bis_rd = 1'b0;
   logic [7:0] rd_mem [256];
   logic [7:0] rd_idx = '0;
   logic [7:0] rd_wi = '0;

   always @(posedge clk) begin
      case (bst)
         0: if (br_read_sig || br_write_sig) begin
            bis_rd <= br_read_sig;
            bst    <= 1;
         end
         1: bst <= 2;
         2: begin
            bst         <= 3;
            br_finished <= 1'b1;
            if (bis_rd) begin
               br_read_data <= rd_mem[rd_idx];
               rd_idx       <= rd_idx + 8'd1;
            end
         end
         default: begin
            bst         <= 0;
            br_finished <= 1'b0;
         end
      endcase
   end

   int         ntest = 0, nfail = 0;
   int         cyc = 0, pend_m = 0, nwr = 0, nrd = 0, npop = 0;
   logic [7:0] exp_wr[$], exp_rx[$], rx_log[$], gq[$];
   int         wrise[$];
   logic       saw_full = 1'b0, pw = 1'b0, pr = 1'b0;
   logic [7:0] wd_hold = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntest++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            exp_wr.delete();
            exp_rx.delete();
            pend_m = 0;
            nwr = 0;
            nrd = 0;
            chk("rst_tx_ready", tx_ready, 1);
            chk("rst_rx_valid", rx_valid, 0);
            chk("rst_sigs", {br_write_sig, br_read_sig}, 0);
            chk("rst_wdata", br_write_data, 0);
            chk("rst_busy", busy, 0);
            chk("rst_levels", {tx_level, rx_level}, 0);
`ifdef USB_LINK_STATS_EN
            chk("rst_counts", {tx_count, rx_count}, 0);
`endif
            pw = 1'b0;
            pr = 1'b0;
         end else begin
            chk("sig_excl", br_write_sig && br_read_sig, 0);
            chk("tx_level", tx_level, exp_wr.size());
            chk("rx_level", rx_level, exp_rx.size());
            chk("tx_ready", tx_ready, exp_wr.size() < 16);
            chk("rx_valid", rx_valid, exp_rx.size() != 0);
            chk("busy", busy, br_write_sig || br_read_sig || exp_wr.size() != 0 || pend_m != 0);
`ifdef USB_LINK_STATS_EN
            chk("tx_count", tx_count, nwr & 32'hFFFF);
            chk("rx_count", rx_count, nrd & 32'hFFFF);
`endif
            if (!tx_ready) saw_full = 1'b1;
            if (br_write_sig && !pw) begin
               gq.push_back("W");
               wrise.push_back(cyc);
               wd_hold = br_write_data;
            end else if (br_write_sig) chk("wdata_stable", br_write_data, wd_hold);
            if (br_read_sig && !pr) begin
               gq.push_back("R");
               chk("rd_grant_space", exp_rx.size() < 16, 1);
            end
            if (br_write_sig && br_finished) begin
               if (exp_wr.size() == 0) chk("wr_unexpected", 0, 1);
               else chk("wr_byte", br_write_data, exp_wr.pop_front());
               nwr++;
            end
            if (rx_valid && rx_ready) begin
               if (exp_rx.size() == 0) chk("rx_unexpected", 0, 1);
               else chk("rx_byte", rx_data, exp_rx.pop_front());
               rx_log.push_back(rx_data);
               npop++;
            end
            if (br_read_sig && br_finished) begin
               exp_rx.push_back(br_read_data);
               pend_m--;
               nrd++;
            end
            if (tx_valid && tx_ready) exp_wr.push_back(tx_data);
            if (rd_start && rd_len != 0) pend_m = (pend_m + rd_len > 65535) ? 65535 : pend_m + rd_len;
            pw = br_write_sig;
            pr = br_read_sig;
         end
      end
   endtask

   task automatic send(input logic [7:0] b);
      int   n = 0;
      logic acc;
      tx_valid = 1'b1;
      tx_data  = b;
      forever begin
         @(negedge clk);
         acc = tx_ready;
         @(posedge clk);
         #1;
         if (acc) break;
         if (++n > 200) begin
            chk("send_timeout", n, 0);
            break;
         end
      end
      tx_valid = 1'b0;
   endtask

   task automatic rd(input logic [7:0] len);
      rd_start = 1'b1;
      rd_len   = len;
      @(posedge clk);
      #1;
      rd_start = 1'b0;
      rd_len   = '0;
   endtask

   task automatic add_rd(input logic [7:0] v);
      rd_mem[rd_wi] = v;
      rd_wi = rd_wi + 8'd1;
   endtask

   task automatic wait_quiet(input string nm, input int lim);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(busy == 1'b0 && bst == 0 && (!rx_ready || !rx_valid)) && n < lim);
      if (n >= lim) chk({nm, "_timeout"}, n, 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int    w0, g0, n0, p0, n;
      string pat;
      fork
         monitor();
      join_none
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // two writes in order, 5 cycles rise to rise
      w0 = wrise.size();
      send(8'hA5);
      send(8'h3C);
      wait_quiet("t2", 100);
      chk("t2_writes", nwr, 2);
      if (wrise.size() >= w0 + 2) chk("t2_gap", wrise[w0+1] - wrise[w0], 5);
      else chk("t2_rises", wrise.size() - w0, 2);

      // counted read of three bytes
      rx_ready = 1'b1;
      add_rd(8'h11);
      add_rd(8'h22);
      add_rd(8'h33);
      p0 = rx_log.size();
      rd(8'd3);
      wait_quiet("t3", 100);
      chk("t3_reads", nrd, 3);
      chk("t3_pops", rx_log.size() - p0, 3);
      if (rx_log.size() >= p0 + 3) begin
         chk("t3_rx0", rx_log[p0], 8'h11);
         chk("t3_rx1", rx_log[p0+1], 8'h22);
         chk("t3_rx2", rx_log[p0+2], 8'h33);
      end

      // contention: reads and writes alternate, TX FIFO fills
      g0 = gq.size();
      saw_full = 1'b0;
      n0 = nwr;
      repeat (4) add_rd(8'($urandom));
      rd(8'd4);
      repeat (24) send(8'($urandom));
      wait_quiet("t4", 400);
      pat = "RWRWRWRW";
      for (int i = 0; i < 8; i++) begin
         if (gq.size() > g0 + i) chk("t4_grant_order", gq[g0+i], pat[i]);
         else chk("t4_grant_missing", gq.size(), g0 + i + 1);
      end
      chk("t4_full_seen", saw_full, 1);
      chk("t4_writes", nwr - n0, 24);

      // RX back-pressure stalls reads at 16
      rx_ready = 1'b0;
      n0 = nrd;
      p0 = npop;
      repeat (20) add_rd(8'($urandom));
      rd(8'd20);
      n = 0;
      while (nrd - n0 < 16 && n < 300) begin
         @(negedge clk);
         n++;
      end
      repeat (20) @(negedge clk);
      chk("t5_stalled_reads", nrd - n0, 16);
      chk("t5_read_sig_low", br_read_sig, 0);
      chk("t5_busy", busy, 1);
      chk("t5_rx_level", rx_level, 16);
      @(posedge clk);
      #1;
      rx_ready = 1'b1;
      wait_quiet("t5", 300);
      chk("t5_total_reads", nrd - n0, 20);
      chk("t5_total_pops", npop - p0, 20);

      // reset during WRITE, stray finished ignored
      send(8'($urandom));
      n = 0;
      while (!br_write_sig && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t6_write_started", br_write_sig, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6_async_drop", br_write_sig, 0);
      chk("t6_tx_flushed", tx_level, 0);
      chk("t6_busy", busy, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("t6_no_stray_write", nwr, 0);
      send(8'h77);
      wait_quiet("t6", 100);
      chk("t6_write_after", nwr, 1);

      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end

endmodule
